ifetch_unit: RTL

- Instruction-fetch stage, directly upstream of the immediate extender and the decoder.
- Holds the PC and fetches one 32-bit word per instruction over a req/ack instruction-memory port.
- Presents the latched instruction, its PC, PC+4 and the raw 16-bit immediate field to decode through a valid/ready handshake.
- Accepts branch/jump redirects from execute.

---
 rtl/ifetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, req/ack imem port, and a valid/ready hand-off to decode.
// Optional macro IFETCH_ALIGN_CHECK_EN enables the sticky misaligned-redirect flag fetch_err.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [15:0] id_imm16,
    output logic        fetch_err
);

    typedef enum logic {
        S_REQ = 1'b0,
        S_OUT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        fetch_fire;
    logic [31:0] redirect_target;

    // Requests are suppressed while reset is held so memory never sees a stale issue.
    assign imem_req        = rst_n && (state_q == S_REQ) && !stall;
    assign imem_addr       = pc_q;
    assign fetch_fire      = imem_req && imem_ack;
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    assign id_valid  = (state_q == S_OUT);
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_pc4    = id_pc_q + 32'd4;
    assign id_imm16  = id_instr_q[15:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;

        // A redirect overrides everything: same-cycle ack and id_ready are both dropped.
        if (redirect_valid) begin
            pc_d    = redirect_target;
            state_d = S_REQ;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (fetch_fire) begin
                        id_instr_d = imem_rdata;
                        id_pc_d    = pc_q;
                        pc_d       = pc_q + 32'd4;
                        state_d    = S_OUT;
                    end
                end
                S_OUT: begin
                    if (id_ready) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            id_instr_q <= 32'h0000_0000;
            id_pc_q    <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fetch_err_q, fetch_err_d;

    always_comb begin
        fetch_err_d = fetch_err_q;
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            fetch_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    // Low target bits are simply discarded when alignment checking is off.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign fetch_err            = 1'b0;
`endif

endmodule
